matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
//  Upstream feeder for the matrix multiplier. Accepts a serial stream of words over a stb/ack handshake
//  and assembles them into one flattened ROWS x COLS matrix bus. Presents that bus to the multiplier
//  through the same stb/ack protocol as its matrix_A / matrix_B inputs.
//  One instance feeds A; a second instance feeds B.
// PARAMETERS
//  ROWS        16   matrix rows
//  COLS        16   matrix columns
//  WORD_WIDTH  32   bits per element; fixed at 32 to match the multiplier
// PORTS
//  clk         in   1                    single clock; all logic on the rising edge
//  rst         in   1                    asynchronous reset, active-low
//  in_word     in   WORD_WIDTH           stream element
//  in_stb      in   1                    in_word is valid
//  in_first    in   1                    qualifies in_word as element 0 of a new matrix
//  in_ack      out  1                    loader can accept a word this cycle
//  matrix      out  [0:ROWS*COLS*WORD_WIDTH-1]  assembled matrix; element (r,c) at [(r*COLS+c)*WORD_WIDTH +: WORD_WIDTH]
//  mat_stb     out  1                    matrix is complete and stable
//  mat_ack     in   1                    consumer has taken the matrix
//  loading     out  1                    at least one word of the current matrix has been accepted
// BEHAVIOUR
//  - Reset (rst low, async): state=LOAD, index=0, in_ack=1, mat_stb=0, loading=0, matrix=0.
//  - Transfer: a word is accepted on a rising edge where in_stb && in_ack are both high. in_ack is a
//    registered state decode: 1 in LOAD, 0 in FULL.
//  - LOAD: each accepted word is written to element index k, row-major (r=k/COLS, c=k%COLS), then k++.
//    - loading=1 from the cycle after the first accept.
//    - Accepting k=ROWS*COLS-1 moves to FULL. mat_stb=1 and in_ack=0 on the next cycle
//      (latency: 1 cycle from last accept to mat_stb).
//  - in_first accepted: k restarts at 0 and the word is written to element 0. This overrides any
//    partial fill (resync); stale elements are overwritten as the stream progresses.
//  - in_first with ROWS*COLS==1: the loader goes directly to FULL.
//  - Accepted word with in_first=0 while k==0: a valid element 0 (in_first is optional on a clean start).
//  - FULL:
//    - matrix is held constant; in_stb is ignored (in_ack=0).
//    - mat_ack sampled high -> next cycle mat_stb=0, loading=0, k=0, in_ack=1, state=LOAD.
//    - mat_ack high while mat_stb=0 is ignored.
//  - Index counter: width $clog2(ROWS*COLS) (minimum 1). It never wraps past ROWS*COLS-1; the
//    transition to FULL replaces the wrap.
//  - States: LOAD(0), FULL(1). No other encodings; an illegal state recovers to LOAD.
//  - Reset mid-load or mid-FULL: immediate return to reset values; the partial matrix is discarded.
// CONFIGURATION
//  - MATRIX_LOADER_TRANSPOSE_EN defined:
//    - stream word k is stored at element (c,r) of a COLS x ROWS bus, i.e. bit offset
//      (c*ROWS+r)*WORD_WIDTH, with r=k/COLS and c=k%COLS.
//    - Lets B be streamed row-major but delivered column-major.
//    - Handshake and timing are unchanged.
//  - Undefined: row-major storage as above.
// STRUCTURE
//  - Shared package matrix_pkg:
//    - WORD_WIDTH=32
//    - loader state encoding (LOAD/FULL), shared with other stream blocks
//    - function elem_offset(r,c,ncols), returning the bit offset of an element
//  - One sub-module, mtx_index_counter:
//    - tracks r/c with nested row/column counters, avoiding divide/modulo
//    - inputs: clk, rst, inc, clr, and load0, which forces index 1 after in_first is accepted at 0
//    - outputs: r, c, last
// TESTING (ROWS=COLS=2 unless stated)
//  1. Stream 1,2,3,4 back-to-back, first on word 1 -> mat_stb rises 1 cycle after the 4th accept.
//     matrix = {1,2,3,4}; in_ack=0 while FULL.
//  2. Hold mat_ack=0 for 10 cycles, in_stb=1 throughout -> matrix unchanged and no words accepted.
//     Pulse mat_ack -> mat_stb=0 and in_ack=1 on the next cycle.
//  3. Stream 9,8, then in_first with 1, then 2,3,4 -> matrix = {1,2,3,4} and exactly one mat_stb event.
//  4. Assert rst low after 3 accepts -> all outputs at reset values on the same edge.
//     Full restream 5,6,7,8 -> matrix = {5,6,7,8}.
//  5. Define MATRIX_LOADER_TRANSPOSE_EN, stream 1,2,3,4 -> matrix = {1,3,2,4}.
//  6. ROWS=3, COLS=2 with in_stb toggling every other cycle -> 6 accepts, mat_stb after the 6th,
//     row-major order preserved.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream blocks: word width, loader state
// encoding and element bit-offset helper.
package matrix_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } ldr_state_t;

  // Bit offset of element (r,c) in a flattened row-major bus with ncols columns.
  function automatic int unsigned elem_offset(int unsigned r, int unsigned c, int unsigned ncols);
    return (r * ncols + c) * WORD_WIDTH;
  endfunction

  // Counter width for a range of n values, never less than one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_stream_loader_if.sv
// Stream-in and matrix-out handshake bundle for matrix_stream_loader.
interface matrix_stream_loader_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) ();

  logic [matrix_pkg::WORD_WIDTH-1:0]            in_word;
  logic                                         in_stb;
  logic                                         in_first;
  logic                                         in_ack;
  logic [0:ROWS*COLS*matrix_pkg::WORD_WIDTH-1]  matrix;
  logic                                         mat_stb;
  logic                                         mat_ack;
  logic                                         loading;

  modport slave (
    input  in_word, in_stb, in_first, mat_ack,
    output in_ack, matrix, mat_stb, loading
  );

  modport master (
    output in_word, in_stb, in_first, mat_ack,
    input  in_ack, matrix, mat_stb, loading
  );

endinterface

// File: rtl/mtx_index_counter.sv
// Row/column element index for the stream loader, kept as nested counters so
// no divide or modulo is needed to locate the element being written.
module mtx_index_counter
  import matrix_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     load0,
  output logic [idx_w(ROWS)-1:0]   r,
  output logic [idx_w(COLS)-1:0]   c,
  output logic                     last
);

  localparam int RW = idx_w(ROWS);
  localparam int CW = idx_w(COLS);

  assign last = (r == RW'(ROWS - 1)) && (c == CW'(COLS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (load0) begin
      // element 0 was just written by a resync word, so the next one is index 1
      if (COLS > 1) begin
        r <= '0;
        c <= CW'(1);
      end else if (ROWS > 1) begin
        r <= RW'(1);
        c <= '0;
      end else begin
        r <= '0;
        c <= '0;
      end
    end else if (inc) begin
      if (c == CW'(COLS - 1)) begin
        c <= '0;
        r <= (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matrix_stream_loader.sv
// Assembles a serial word stream into one flattened ROWS x COLS matrix and
// hands it downstream over stb/ack. Define MATRIX_LOADER_TRANSPOSE_EN to store column-major.
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_stream_loader_if.slave  bus
);

  localparam int NELEM = ROWS * COLS;
  localparam int RW    = idx_w(ROWS);
  localparam int CW    = idx_w(COLS);
  localparam int OFFW  = $clog2(NELEM * WORD_WIDTH);

  ldr_state_t state, state_nxt;

  logic                        accept;
  logic                        inc, clr, load0, we;
  logic [RW-1:0]               r;
  logic [CW-1:0]               c;
  logic                        last;
  int unsigned                 wr_r, wr_c;
  logic [OFFW-1:0]             off;
  logic [0:NELEM*WORD_WIDTH-1] mat_q;
  logic                        loading_q;

  mtx_index_counter #(.ROWS(ROWS), .COLS(COLS)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .clr   (clr),
    .load0 (load0),
    .r     (r),
    .c     (c),
    .last  (last)
  );

  assign bus.in_ack  = (state == LOAD);
  assign bus.mat_stb = (state == FULL);
  assign bus.matrix  = mat_q;
  assign bus.loading = loading_q;
  assign accept      = bus.in_stb && bus.in_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inc       = 1'b0;
    clr       = 1'b0;
    load0     = 1'b0;
    we        = 1'b0;
    case (state)
      LOAD: begin
        if (accept) begin
          we = 1'b1;
          if (bus.in_first) begin
            if (NELEM == 1) state_nxt = FULL;
            else            load0     = 1'b1;
          end else if (last) begin
            // index holds at the last element until the consumer acks
            state_nxt = FULL;
          end else begin
            inc = 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.mat_ack) begin
          state_nxt = LOAD;
          clr       = 1'b1;
        end
      end
      default: begin
        state_nxt = LOAD;
        clr       = 1'b1;
      end
    endcase
  end

  // A resync word always lands on element 0 regardless of the running index.
  always_comb begin
    wr_r = bus.in_first ? 32'd0 : 32'(r);
    wr_c = bus.in_first ? 32'd0 : 32'(c);
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    off  = OFFW'(elem_offset(wr_c, wr_r, ROWS));
`else
    off  = OFFW'(elem_offset(wr_r, wr_c, COLS));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    mat_q <= '0;
    else if (we) mat_q[off +: WORD_WIDTH] <= bus.in_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             loading_q <= 1'b0;
    else if (state == FULL && bus.mat_ack) loading_q <= 1'b0;
    else if (accept)                      loading_q <= 1'b1;
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader: vector table, directed corner
// sequences and a random run against a queue/array reference model.
module tb_matrix_stream_loader;
  import matrix_pkg::*;

  localparam int R  = 2, C  = 2, N  = R * C;
  localparam int R3 = 3, C3 = 2, N3 = R3 * C3;
  localparam int W  = WORD_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_stream_loader_if #(.ROWS(R),  .COLS(C))  bus  ();
  matrix_stream_loader_if #(.ROWS(R3), .COLS(C3)) bus3 ();

  matrix_stream_loader #(.ROWS(R),  .COLS(C))  dut  (.clk(clk), .rst(rst), .bus(bus));
  matrix_stream_loader #(.ROWS(R3), .COLS(C3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: element values by stream index, plus full/loading flags.
  bit             m_full, m_loading;
  int             m_k;
  logic [W-1:0]   m_el [N];
  bit             prev_stb;
  int             stb_rises;

  task automatic model_reset();
    m_full = 0; m_loading = 0; m_k = 0;
    foreach (m_el[i]) m_el[i] = '0;
  endtask

  function automatic logic [0:N*W-1] m_mat();
    logic [0:N*W-1] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
      v[((k % C) * R + k / C) * W +: W] = m_el[k];
`else
      v[((k / C) * C + k % C) * W +: W] = m_el[k];
`endif
    end
    return v;
  endfunction

  function automatic logic [0:N*W-1] mat4(input logic [W-1:0] a, b, d, e);
    logic [W-1:0] w [N];
    logic [0:N*W-1] v;
    w[0] = a; w[1] = b; w[2] = d; w[3] = e;
    v = '0;
    for (int k = 0; k < N; k++) begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
      v[((k % C) * R + k / C) * W +: W] = w[k];
`else
      v[k * W +: W] = w[k];
`endif
    end
    return v;
  endfunction

  // One clock of stimulus on the 2x2 loader; the model advances and all outputs are compared.
  task automatic cyc(input bit stb, input bit first, input logic [W-1:0] word, input bit ack);
    int idx;
    bus.in_stb = stb; bus.in_first = first; bus.in_word = word; bus.mat_ack = ack;
    if (stb && !m_full) begin
      idx = first ? 0 : m_k;
      m_el[idx] = word;
      m_loading = 1;
      if (idx == N - 1) begin m_full = 1; m_k = 0; end
      else m_k = idx + 1;
    end else if (m_full && ack) begin
      m_full = 0; m_loading = 0; m_k = 0;
    end
    @(posedge clk); #1;
    chk("in_ack",  bus.in_ack,  !m_full);
    chk("mat_stb", bus.mat_stb, m_full);
    chk("loading", bus.loading, m_loading);
    chk("matrix",  bus.matrix,  m_mat());
    if (bus.mat_stb && !prev_stb) stb_rises++;
    prev_stb = bus.mat_stb;
  endtask

  typedef struct {
    bit           stb, first;
    logic [W-1:0] word;
    bit           ack;
    bit           e_in_ack, e_mat_stb, e_loading;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    int acc3, rise_at;
    bit s, a;
    logic [0:N3*W-1] e3;

    rst = 1'b0;
    bus.in_stb = 0;  bus.in_first = 0;  bus.in_word = '0;  bus.mat_ack = 0;
    bus3.in_stb = 0; bus3.in_first = 0; bus3.in_word = '0; bus3.mat_ack = 0;
    model_reset();
    prev_stb = 0; stb_rises = 0;

    #12;
    chk("reset_in_ack",  bus.in_ack,  1'b1);
    chk("reset_mat_stb", bus.mat_stb, 1'b0);
    chk("reset_loading", bus.loading, 1'b0);
    chk("reset_matrix",  bus.matrix,  '0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // fill 1..4, hold FULL for 10 cycles with stb high, then ack; stray ack ignored
    tbl.push_back('{1, 1, 32'd1, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 32'd2, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 32'd3, 0, 1, 0, 1});
    tbl.push_back('{1, 0, 32'd4, 0, 0, 1, 1});
    for (int i = 0; i < 10; i++) tbl.push_back('{1, 0, 32'hDEAD_0000 + i, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 32'hBEEF, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 32'h0, 1, 1, 0, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cyc(v.stb, v.first, v.word, v.ack);
      chk($sformatf("tbl%0d_in_ack", i),  bus.in_ack,  v.e_in_ack);
      chk($sformatf("tbl%0d_mat_stb", i), bus.mat_stb, v.e_mat_stb);
      chk($sformatf("tbl%0d_loading", i), bus.loading, v.e_loading);
      if (i == 3 || i == 13) chk($sformatf("tbl%0d_matrix", i), bus.matrix, mat4(1, 2, 3, 4));
    end

    // resync: 9,8 then in_first restarts the fill
    stb_rises = 0;
    cyc(1, 1, 32'd9, 0);
    cyc(1, 0, 32'd8, 0);
    cyc(1, 1, 32'd1, 0);
    cyc(1, 0, 32'd2, 0);
    cyc(1, 0, 32'd3, 0);
    chk("resync_not_full", bus.mat_stb, 1'b0);
    cyc(1, 0, 32'd4, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'd0, 0);
    chk("resync_stb_events", stb_rises, 1);
    chk("resync_matrix", bus.matrix, mat4(1, 2, 3, 4));
    cyc(0, 0, 32'd0, 1);

    // async reset mid-load discards the partial matrix
    cyc(1, 0, 32'd11, 0);
    cyc(1, 0, 32'd12, 0);
    cyc(1, 0, 32'd13, 0);
    bus.in_stb = 0;
    #2 rst = 1'b0;
    #1;
    chk("midreset_in_ack",  bus.in_ack,  1'b1);
    chk("midreset_mat_stb", bus.mat_stb, 1'b0);
    chk("midreset_loading", bus.loading, 1'b0);
    chk("midreset_matrix",  bus.matrix,  '0);
    model_reset();
    prev_stb = 0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 32'd5, 0);
    cyc(1, 0, 32'd6, 0);
    cyc(1, 0, 32'd7, 0);
    cyc(1, 0, 32'd8, 0);
    chk("restream_matrix", bus.matrix, mat4(5, 6, 7, 8));
    cyc(0, 0, 32'd0, 1);

    // 3x2 loader with in_stb on every other cycle
    acc3 = 0; rise_at = -1;
    for (int i = 0; i < 14; i++) begin
      s = (i % 2 == 0);
      bus3.in_stb = s; bus3.in_first = (i == 0); bus3.in_word = 32'(acc3 + 1); bus3.mat_ack = 0;
      a = s && bus3.in_ack;
      @(posedge clk); #1;
      if (a) acc3++;
      if (bus3.mat_stb && rise_at < 0) rise_at = i;
    end
    e3 = '0;
    for (int k = 0; k < N3; k++) begin
`ifdef MATRIX_LOADER_TRANSPOSE_EN
      e3[((k % C3) * R3 + k / C3) * W +: W] = 32'(k + 1);
`else
      e3[k * W +: W] = 32'(k + 1);
`endif
    end
    chk("r3c2_accepts",   acc3, 6);
    chk("r3c2_stb_cycle", rise_at, 10);
    chk("r3c2_in_ack",    bus3.in_ack, 1'b0);
    chk("r3c2_matrix",    bus3.matrix, e3);
    bus3.in_stb = 0; bus3.mat_ack = 1;
    @(posedge clk); #1;
    bus3.mat_ack = 0;
    chk("r3c2_release", bus3.mat_stb, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 3) == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
